rah_app_arbiter: RTL and testbench

- Shares one processing engine (e.g. a CORDIC core) among N_CH RAH application channels.
- Read side: pulls packets from the per-app decoder queues using round-robin arbitration.
- Engine side: presents each packet to the engine over a valid/ready handshake with a channel tag.
- Return side: routes the in-order engine results back to the originating channel's encoder write port.
- Sits between rah_decoder/rah_encoder and a shared compute core. Replaces one hard-wired app instance per channel.

---
 rtl/rah_arb_pkg.sv | 24 ++
 rtl/rah_tag_fifo.sv | 53 +++++
 rtl/rah_app_arbiter.sv | 141 ++++++++++++++
 tb/tb_rah_app_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rah_arb_pkg.sv
// Shared types and helpers for the RAH application arbiter.
// Provides the issue FSM encoding, tag-width derivation and per-channel bus slicing.
`ifndef RAH_ARB_PKG_SV
`define RAH_ARB_PKG_SV

// Part-select for channel idx of a packed per-channel bus of w-bit slices.
`define RAH_ARB_SLICE(idx, w) (idx)*(w) +: (w)

package rah_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        OFFER   = 2'd2
    } issue_state_e;

    // A single channel still needs a 1-bit tag so ports never collapse to zero width.
    function automatic int calc_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/rah_tag_fifo.sv
// In-order FIFO of channel tags for packets currently inside the engine.
// Registered occupancy count; push and pop may happen in the same cycle.
module rah_tag_fifo
    import rah_arb_pkg::*;
#(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push at full only lands when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rah_app_arbiter.sv
// Shares one engine among N_CH RAH app channels: round-robin issue, in-order return.
// Optional RAH_ARB_CH0_PRIORITY_EN gives channel 0 strict priority over the round-robin.
module rah_app_arbiter
    import rah_arb_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int DATA_WIDTH = 48,
    parameter  int TAG_DEPTH  = 4,
    localparam int CH_W       = calc_ch_w(N_CH),
    localparam int CNT_W      = $clog2(TAG_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            ch_empty,
    output logic [N_CH-1:0]            ch_rd_en,
    input  logic [N_CH*DATA_WIDTH-1:0] ch_rd_data,
    output logic                       eng_valid,
    input  logic                       eng_ready,
    output logic [DATA_WIDTH-1:0]      eng_data,
    output logic [CH_W-1:0]            eng_tag,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [DATA_WIDTH-1:0]      res_data,
    output logic [N_CH-1:0]            ch_wr_en,
    output logic [N_CH*DATA_WIDTH-1:0] ch_wr_data,
    input  logic [N_CH-1:0]            ch_wr_full,
    output logic [CNT_W-1:0]           outstanding,
    output logic                       err_orphan
);

    issue_state_e    state_q, state_d;
    logic [CH_W-1:0] rr_ptr, gnt_q, gnt_idx, head_tag;
    logic            gnt_found, tag_push, tag_pop, tag_full, tag_empty;
    int              c;

    // Grant pick: first non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        c         = 0;
`ifdef RAH_ARB_CH0_PRIORITY_EN
        if (!ch_empty[0]) begin
            gnt_found = 1'b1;
        end else
`endif
        for (int i = 0; i < N_CH; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= N_CH) c = c - N_CH;
            if (!gnt_found && !ch_empty[c]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ch_rd_en = '0;
        tag_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_found && !tag_full) begin
                    ch_rd_en[gnt_idx] = 1'b1;
                    state_d           = CAPTURE;
                end
            end
            CAPTURE: begin
                // Tag enters the FIFO before the packet is offered, so results never outrun it.
                tag_push = 1'b1;
                state_d  = OFFER;
            end
            OFFER: begin
                if (eng_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            rr_ptr    <= '0;
            eng_valid <= 1'b0;
            eng_data  <= '0;
            eng_tag   <= '0;
        end else begin
            if (state_q == IDLE && state_d == CAPTURE) gnt_q <= gnt_idx;
            if (state_q == CAPTURE) begin
                eng_valid <= 1'b1;
                eng_data  <= ch_rd_data[`RAH_ARB_SLICE(gnt_q, DATA_WIDTH)];
                eng_tag   <= gnt_q;
`ifdef RAH_ARB_CH0_PRIORITY_EN
                if (gnt_q != '0)
`endif
                rr_ptr <= (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + 1'b1;
            end else if (state_q == OFFER && eng_ready) begin
                eng_valid <= 1'b0;
            end
        end
    end

    rah_tag_fifo #(
        .WIDTH (CH_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_push),
        .push_data (gnt_q),
        .pop       (tag_pop),
        .head      (head_tag),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // A full head channel blocks every return behind it; results are strictly in order.
    assign res_ready = !tag_empty && !ch_wr_full[head_tag];
    assign tag_pop   = res_valid && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_wr_en   <= '0;
            ch_wr_data <= '0;
            err_orphan <= 1'b0;
        end else begin
            ch_wr_en <= '0;
            if (tag_pop) begin
                ch_wr_en[head_tag]                              <= 1'b1;
                ch_wr_data[`RAH_ARB_SLICE(head_tag, DATA_WIDTH)] <= res_data;
            end
            if (res_valid && tag_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rah_app_arbiter.sv
// Scoreboard bench for rah_app_arbiter: directed vectors, decoupled monitor.
module tb_rah_app_arbiter;

    localparam int N_CH  = 4;
    localparam int DW    = 48;
    localparam int TD    = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_CH-1:0]      ch_empty = '1;
    logic [N_CH-1:0]      ch_rd_en;
    logic [N_CH*DW-1:0]   ch_rd_data = '0;
    logic                 eng_valid;
    logic                 eng_ready = 1'b1;
    logic [DW-1:0]        eng_data;
    logic [CH_W-1:0]      eng_tag;
    logic                 res_valid;
    logic                 res_ready;
    logic [DW-1:0]        res_data = '0;
    logic [N_CH-1:0]      ch_wr_en;
    logic [N_CH*DW-1:0]   ch_wr_data;
    logic [N_CH-1:0]      ch_wr_full = '0;
    logic [CNT_W-1:0]     outstanding;
    logic                 err_orphan;

    always #5 clk = ~clk;

    rah_app_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n), .ch_empty(ch_empty), .ch_rd_en(ch_rd_en),
        .ch_rd_data(ch_rd_data), .eng_valid(eng_valid), .eng_ready(eng_ready),
        .eng_data(eng_data), .eng_tag(eng_tag), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .ch_wr_en(ch_wr_en),
        .ch_wr_data(ch_wr_data), .ch_wr_full(ch_wr_full),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    typedef struct { int ch; logic [DW-1:0] d; } xact_t;
    typedef struct { string name; int sel; logic [63:0] exp; } chk_t;
    typedef struct { logic [DW-1:0] d; int t; } epipe_t;

    xact_t  exp_tag[$];
    xact_t  exp_wr[$];
    chk_t   chkq[$];
    epipe_t epipe[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;

    logic [DW-1:0] dmem [N_CH][16];
    int            nload [N_CH] = '{default: 0};
    int            rd_idx[N_CH] = '{default: 0};
    bit            engine_en = 1'b1;
    bit            force_rv = 1'b0;
    logic          eng_rv = 1'b0;

    assign res_valid = eng_rv | force_rv;

    // Decoder queues plus an engine that echoes data+1 two cycles after acceptance.
    always @(posedge clk) begin
        logic [N_CH-1:0] rde;
        logic            eh, rh;
        logic [DW-1:0]   ed;
        rde = ch_rd_en;
        eh  = eng_valid && eng_ready;
        rh  = res_valid && res_ready;
        ed  = eng_data;
        cyc++;
        #1;
        if (!rst_n) begin
            epipe.delete();
            for (int i = 0; i < N_CH; i++) rd_idx[i] = 0;
        end else begin
            if (rh && epipe.size() > 0) void'(epipe.pop_front());
            if (eh) epipe.push_back('{ed + 1, cyc + 2});
            for (int i = 0; i < N_CH; i++) begin
                if (rde[i]) begin
                    ch_rd_data[i*DW +: DW] = dmem[i][rd_idx[i] & 15];
                    rd_idx[i]++;
                end
            end
        end
        for (int i = 0; i < N_CH; i++) ch_empty[i] = (rd_idx[i] >= nload[i]);
        eng_rv   = engine_en && epipe.size() > 0 && cyc >= epipe[0].t;
        res_data = (epipe.size() > 0) ? epipe[0].d : '0;
    end

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            0:       return 64'(outstanding);
            1:       return 64'(err_orphan);
            2:       return 64'(res_ready);
            3:       return 64'(eng_valid);
            4:       return 64'(ch_rd_en);
            5:       return 64'(ch_wr_en);
            6:       return 64'(rd_idx[1]);
            7:       return 64'(exp_wr.size() + exp_tag.size());
            default: return 64'hdead;
        endcase
    endfunction

    always @(negedge clk) begin
        chk_t          c;
        xact_t         e;
        logic [63:0]   act;
        while (chkq.size() != 0) begin
            c   = chkq.pop_front();
            act = pick(c.sel);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
            end
        end
        if (rst_n) begin
            if (ch_rd_en != '0) begin
                checks++;
                if (!$onehot(ch_rd_en)) begin
                    errors++;
                    $display("FAIL rd_onehot: got %b expected one-hot", ch_rd_en);
                end
            end
            if (eng_valid && eng_ready) begin
                checks++;
                if (exp_tag.size() == 0) begin
                    errors++;
                    $display("FAIL issue: got tag %0d data %0h expected no issue", eng_tag, eng_data);
                end else begin
                    e = exp_tag.pop_front();
                    if (eng_tag !== CH_W'(e.ch) || eng_data !== e.d) begin
                        errors++;
                        $display("FAIL issue: got tag %0d data %0h expected tag %0d data %0h",
                                 eng_tag, eng_data, e.ch, e.d);
                    end
                end
            end
            if (ch_wr_en != '0) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write: got en %b expected no write", ch_wr_en);
                end else begin
                    e = exp_wr.pop_front();
                    if (ch_wr_en !== N_CH'(1 << e.ch) || ch_wr_data[e.ch*DW +: DW] !== e.d) begin
                        errors++;
                        $display("FAIL write: got en %b data %0h expected ch %0d data %0h",
                                 ch_wr_en, ch_wr_data[e.ch*DW +: DW], e.ch, e.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int sel, input logic [63:0] exp);
        chkq.push_back('{name, sel, exp});
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        nload      = '{default: 0};
        ch_wr_full = '0;
        engine_en  = 1'b1;
        eng_ready  = 1'b1;
        force_rv   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic load(input int ch, input int n, input logic [DW-1:0] base, input int step);
        for (int k = 0; k < n; k++) dmem[ch][k] = base + DW'(k * step);
        nload[ch] = n;
    endtask

    task automatic expect_issue(input int ch, input logic [DW-1:0] d);
        exp_tag.push_back('{ch, d});
        exp_wr.push_back('{ch, d + 1});
    endtask

    task automatic drain(input string name, input int maxc);
        int k = 0;
        while ((exp_wr.size() + exp_tag.size()) != 0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(name, 7, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_eng_valid", 3, 0);
        chk("rst_rd_en", 4, 0);
        chk("rst_wr_en", 5, 0);
        chk("rst_outstanding", 0, 0);
        chk("rst_err_orphan", 1, 0);
        chk("rst_res_ready", 2, 0);
        release_reset();

        // Orphan result with nothing issued
        force_rv = 1'b1;
        chk("orphan_res_ready", 2, 0);
        @(negedge clk);
        force_rv = 1'b0;
        chk("orphan_sticky", 1, 1);
        repeat (3) @(negedge clk);
        chk("orphan_still_set", 1, 1);
        do_reset();
        chk("orphan_cleared", 1, 0);
        release_reset();

        // Single channel stream, echo +1
        load(2, 3, 48'hA1, 1);
        expect_issue(2, 48'hA1);
        expect_issue(2, 48'hA2);
        expect_issue(2, 48'hA3);
        drain("drain_single_ch", 200);
        chk("single_outstanding", 0, 0);

        // All channels busy: round-robin order
        do_reset();
        release_reset();
        for (int i = 0; i < N_CH; i++) load(i, 2, 48'hB0 + DW'(i), 4);
`ifdef RAH_ARB_CH0_PRIORITY_EN
        expect_issue(0, 48'hB0); expect_issue(0, 48'hB4);
        expect_issue(1, 48'hB1); expect_issue(2, 48'hB2); expect_issue(3, 48'hB3);
        expect_issue(1, 48'hB5); expect_issue(2, 48'hB6); expect_issue(3, 48'hB7);
`else
        for (int k = 0; k < 8; k++) expect_issue(k % 4, 48'hB0 + DW'(k));
`endif
        drain("drain_rr_all", 300);

        // Engine stalls results: issue stops at TAG_DEPTH
        do_reset();
        engine_en = 1'b0;
        release_reset();
        load(1, 6, 48'hC0, 1);
        for (int k = 0; k < 6; k++) expect_issue(1, 48'hC0 + DW'(k));
        repeat (40) @(negedge clk);
        chk("stall_outstanding", 0, TD);
        chk("stall_reads", 6, TD);
        chk("stall_no_offer", 3, 0);
        engine_en = 1'b1;
        drain("drain_stall", 300);

        // Head-of-line block on a full encoder
        do_reset();
        engine_en  = 1'b0;
        ch_wr_full = 4'b0010;
        release_reset();
        load(1, 1, 48'hD1, 1);
        load(3, 1, 48'hD3, 1);
        expect_issue(1, 48'hD1);
        expect_issue(3, 48'hD3);
        repeat (15) @(negedge clk);
        chk("hol_outstanding", 0, 2);
        engine_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("hol_res_ready", 2, 0);
        chk("hol_no_pop", 0, 2);
        ch_wr_full = '0;
        drain("drain_hol", 100);
        chk("hol_done_outstanding", 0, 0);

        // Channel 0 vs channel 1 contention
        do_reset();
        release_reset();
        load(0, 6, 48'hE0, 1);
        load(1, 3, 48'hF0, 1);
`ifdef RAH_ARB_CH0_PRIORITY_EN
        for (int k = 0; k < 6; k++) expect_issue(0, 48'hE0 + DW'(k));
        for (int k = 0; k < 3; k++) expect_issue(1, 48'hF0 + DW'(k));
`else
        for (int k = 0; k < 3; k++) begin
            expect_issue(0, 48'hE0 + DW'(k));
            expect_issue(1, 48'hF0 + DW'(k));
        end
        for (int k = 3; k < 6; k++) expect_issue(0, 48'hE0 + DW'(k));
`endif
        drain("drain_ch0_ch1", 300);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
